// File: rtl/hw1_2_equiv_sequencer.sv
// Sweeps every NUM_IN-bit code into two function blocks and compares f_a against f_b.
// Optional build macro HW1_2_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module hw1_2_equiv_sequencer #(
    parameter int NUM_IN     = 4,
    parameter int SETTLE_CYC = 1,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [NUM_IN-1:0] vec_out,
    input  logic              f_a,
    input  logic              f_b,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  mismatch_cnt,
    output logic              first_fail_valid,
    output logic [NUM_IN-1:0] first_fail_vec
);
    localparam int             SCW         = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
    localparam logic [SCW-1:0] SETTLE_LOAD = SCW'(SETTLE_CYC);

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [NUM_IN-1:0] r_vec;
    logic [NUM_IN-1:0] r_ff_vec;
    logic [SCW-1:0]    r_settle_cnt;
    logic [CNT_W-1:0]  r_mis_cnt;
    logic              r_ff_valid;
    logic              w_accept;
    logic              w_advance;
    logic              w_mismatch;
    logic              w_last;
    logic              w_stop;

    // Abort suppresses the compare so the counters hold on the aborting edge.
    assign w_mismatch = (r_state == ST_SAMPLE) && !abort && (f_a ^ f_b);
    assign w_last     = (r_vec == '1);

`ifdef HW1_2_STOP_ON_FAIL_EN
    assign w_stop = w_mismatch;
`else
    assign w_stop = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_advance    = 1'b0;
        if (abort) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        w_accept     = 1'b1;
                        w_next_state = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_settle_cnt == '0) begin
                        w_next_state = ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (w_stop || w_last) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_state = ST_SETTLE;
                        w_advance    = 1'b1;
                    end
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec        <= '0;
            r_ff_vec     <= '0;
            r_settle_cnt <= '0;
            r_mis_cnt    <= '0;
            r_ff_valid   <= 1'b0;
        end else if (w_accept) begin
            r_vec        <= '0;
            r_settle_cnt <= SETTLE_LOAD;
            r_mis_cnt    <= '0;
            r_ff_valid   <= 1'b0;
        end else begin
            if ((r_state == ST_SETTLE) && !abort && (r_settle_cnt != '0)) begin
                r_settle_cnt <= r_settle_cnt - SCW'(1);
            end
            if (w_mismatch) begin
                if (r_mis_cnt != '1) begin
                    r_mis_cnt <= r_mis_cnt + CNT_W'(1);
                end
                if (!r_ff_valid) begin
                    r_ff_valid <= 1'b1;
                    r_ff_vec   <= r_vec;
                end
            end
            if (w_advance) begin
                r_vec        <= r_vec + NUM_IN'(1);
                r_settle_cnt <= SETTLE_LOAD;
            end
        end
    end

    assign vec_out          = r_vec;
    assign busy             = (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
    assign done             = (r_state == ST_DONE);
    assign pass             = done && (r_mis_cnt == '0);
    assign mismatch_cnt     = r_mis_cnt;
    assign first_fail_valid = r_ff_valid;
    assign first_fail_vec   = r_ff_vec;

endmodule

// File: tb/tb_hw1_2_equiv_sequencer.sv
// Bench for hw1_2_equiv_sequencer: two instances (defaults, and SETTLE_CYC=0/CNT_W=3) share
// clock, reset, start and abort; each sees its own randomly faulted function pair.
module tb_hw1_2_equiv_sequencer;
    localparam int P1 = 3;   // cycles per vector, SETTLE_CYC=1
    localparam int P2 = 2;   // cycles per vector, SETTLE_CYC=0
    localparam int W1 = 8;
    localparam int W2 = 3;
    localparam int NEVER = 1 << 30;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] tt = '0;
    logic [15:0] mask1 = '0;
    logic [15:0] mask2 = '0;

    logic [3:0]  vec1, vec2, ffvec1, ffvec2;
    logic [7:0]  cnt1;
    logic [2:0]  cnt2;
    logic        busy1, done1, pass1, ffv1;
    logic        busy2, done2, pass2, ffv2;
    logic        fa1, fb1, fa2, fb2;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // f_b differs from the reference f_a exactly on the codes flagged in the mask.
    assign fa1 = tt[vec1];
    assign fb1 = tt[vec1] ^ mask1[vec1];
    assign fa2 = tt[vec2];
    assign fb2 = tt[vec2] ^ mask2[vec2];

    hw1_2_equiv_sequencer #(.NUM_IN(4), .SETTLE_CYC(1), .CNT_W(W1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .vec_out(vec1),
        .f_a(fa1), .f_b(fb1), .busy(busy1), .done(done1), .pass(pass1),
        .mismatch_cnt(cnt1), .first_fail_valid(ffv1), .first_fail_vec(ffvec1)
    );

    hw1_2_equiv_sequencer #(.NUM_IN(4), .SETTLE_CYC(0), .CNT_W(W2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .vec_out(vec2),
        .f_a(fa2), .f_b(fb2), .busy(busy2), .done(done2), .pass(pass2),
        .mismatch_cnt(cnt2), .first_fail_valid(ffv2), .first_fail_vec(ffvec2)
    );

    // Outcome of a sweep whose sample of code v lands on edge (v+1)*p after the start edge;
    // samples on or after edge 'upto' (an abort edge) are not taken.
    function automatic void model(input logic [15:0] mask, input int p, input int cw,
                                  input int upto, output int cnt, output bit ffv,
                                  output int ffvec, output int vec, output int lat);
        cnt = 0; ffv = 1'b0; ffvec = 0; vec = 0; lat = 16 * p;
        for (int v = 0; v < 16; v++) begin
            if ((v + 1) * p >= upto) break;
            vec = (v == 15) ? 15 : v + 1;
            if (mask[v]) begin
                if (cnt < (1 << cw) - 1) cnt++;
                if (!ffv) begin
                    ffv = 1'b1;
                    ffvec = v;
                end
`ifdef HW1_2_STOP_ON_FAIL_EN
                vec = v;
                lat = (v + 1) * p;
                break;
`endif
            end
        end
    endfunction

    // Pulses start, then counts edges until each instance shows done (bounded).
    task automatic run_sweep(input int restart_at, output int lat1, output int lat2,
                             output int bsy1, output int bsy2);
        int n;
        lat1 = -1; lat2 = -1; bsy1 = 0; bsy2 = 0; n = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while ((lat1 < 0 || lat2 < 0) && n < 200) begin
            if (busy1) bsy1++;
            if (busy2) bsy2++;
            if (done1 && lat1 < 0) lat1 = n;
            if (done2 && lat2 < 0) lat2 = n;
            @(posedge clk); #1;
            n++;
            start = (n == restart_at);
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b1;
        #22;
        n_vec++;
        if ({vec1, cnt1, ffv1, ffvec1, busy1, done1, pass1} !== '0) begin
            n_bad++;
            $display("FAIL reset1: got vec=%h cnt=%0d ffv=%b ffvec=%h busy=%b done=%b pass=%b, want all 0",
                     vec1, cnt1, ffv1, ffvec1, busy1, done1, pass1);
        end
        n_vec++;
        if ({vec2, cnt2, ffv2, ffvec2, busy2, done2, pass2} !== '0) begin
            n_bad++;
            $display("FAIL reset2: got vec=%h cnt=%0d ffv=%b ffvec=%h busy=%b done=%b pass=%b, want all 0",
                     vec2, cnt2, ffv2, ffvec2, busy2, done2, pass2);
        end
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_sweeps;
        logic [15:0] tab1 [3] = '{16'h0000, 16'h0020, 16'hFFFF};
        logic [15:0] tab2 [3] = '{16'h0000, 16'h0020, 16'hFFFF};
        int l1, l2, b1, b2, c1, c2, fv1, fv2, v1, v2, e1, e2;
        bit f1, f2;
        for (int i = 0; i < 10; i++) begin
            tt = 16'($urandom);
            if (i < 3) begin
                mask1 = tab1[i];
                mask2 = tab2[i];
            end else begin
                mask1 = 16'($urandom) & 16'($urandom);
                mask2 = (i == 9) ? 16'h0200 : 16'($urandom);
            end
            model(mask1, P1, W1, NEVER, c1, f1, fv1, v1, e1);
            model(mask2, P2, W2, NEVER, c2, f2, fv2, v2, e2);
            // Odd sweeps also pulse start while busy; it must be ignored.
            run_sweep((i % 2 == 1) ? 1 : -1, l1, l2, b1, b2);
            n_vec++;
            if (l1 !== e1 || b1 !== e1) begin
                n_bad++;
                $display("FAIL sweep%0d_time1: done after %0d busy %0d, want %0d", i, l1, b1, e1);
            end
            n_vec++;
            if (l2 !== e2 || b2 !== e2) begin
                n_bad++;
                $display("FAIL sweep%0d_time2: done after %0d busy %0d, want %0d", i, l2, b2, e2);
            end
            n_vec++;
            if (int'(cnt1) !== c1 || pass1 !== (c1 == 0) || ffv1 !== f1) begin
                n_bad++;
                $display("FAIL sweep%0d_cnt1: cnt=%0d pass=%b ffv=%b, want cnt=%0d pass=%b ffv=%b",
                         i, cnt1, pass1, ffv1, c1, (c1 == 0), f1);
            end
            n_vec++;
            if (int'(cnt2) !== c2 || pass2 !== (c2 == 0) || ffv2 !== f2) begin
                n_bad++;
                $display("FAIL sweep%0d_cnt2: cnt=%0d pass=%b ffv=%b, want cnt=%0d pass=%b ffv=%b",
                         i, cnt2, pass2, ffv2, c2, (c2 == 0), f2);
            end
            n_vec++;
            if (int'(vec1) !== v1 || (f1 && int'(ffvec1) !== fv1)) begin
                n_bad++;
                $display("FAIL sweep%0d_vec1: vec=%h ffvec=%h, want vec=%h ffvec=%h", i, vec1, ffvec1, v1, fv1);
            end
            n_vec++;
            if (int'(vec2) !== v2 || (f2 && int'(ffvec2) !== fv2)) begin
                n_bad++;
                $display("FAIL sweep%0d_vec2: vec=%h ffvec=%h, want vec=%h ffvec=%h", i, vec2, ffvec2, v2, fv2);
            end
        end
    endtask

    task automatic test_abort;
        int l1, l2, b1, b2, c1, c2, fv1, fv2, v1, v2, e1, e2;
        bit f1, f2;
        tt = 16'($urandom);
        mask1 = 16'($urandom);
        mask2 = 16'($urandom);
        model(mask1, P1, W1, 20, c1, f1, fv1, v1, e1);
        model(mask2, P2, W2, 20, c2, f2, fv2, v2, e2);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) begin
            @(posedge clk); #1;
        end
        abort = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if ({busy1, done1, pass1, busy2, done2, pass2} !== 6'b0) begin
            n_bad++;
            $display("FAIL abort_state: busy/done/pass = %b%b%b %b%b%b, want 000 000",
                     busy1, done1, pass1, busy2, done2, pass2);
        end
        n_vec++;
        if (int'(cnt1) !== c1 || ffv1 !== f1 || int'(vec1) !== v1 || (f1 && int'(ffvec1) !== fv1)) begin
            n_bad++;
            $display("FAIL abort_hold1: cnt=%0d ffv=%b vec=%h ffvec=%h, want %0d %b %h %h",
                     cnt1, ffv1, vec1, ffvec1, c1, f1, v1, fv1);
        end
        n_vec++;
        if (int'(cnt2) !== c2 || ffv2 !== f2 || int'(vec2) !== v2 || (f2 && int'(ffvec2) !== fv2)) begin
            n_bad++;
            $display("FAIL abort_hold2: cnt=%0d ffv=%b vec=%h ffvec=%h, want %0d %b %h %h",
                     cnt2, ffv2, vec2, ffvec2, c2, f2, v2, fv2);
        end
        mask1 = '0;
        mask2 = '0;
        run_sweep(-1, l1, l2, b1, b2);
        n_vec++;
        if (l1 !== 48 || b1 !== 48 || l2 !== 32 || cnt1 !== 8'd0 || cnt2 !== 3'd0 || !pass1 || !pass2) begin
            n_bad++;
            $display("FAIL abort_restart: lat=%0d/%0d busy1=%0d cnt=%0d/%0d pass=%b%b, want 48/32 48 0/0 11",
                     l1, l2, b1, cnt1, cnt2, pass1, pass2);
        end
    endtask

    task automatic test_reset_mid;
        int l1, l2, b1, b2;
        mask1 = 16'hFFFF;
        mask2 = 16'hFFFF;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #2;
        n_vec++;
        if ({vec1, cnt1, ffv1, ffvec1, busy1, done1, pass1,
             vec2, cnt2, ffv2, ffvec2, busy2, done2, pass2} !== '0) begin
            n_bad++;
            $display("FAIL midreset_async: vec=%h/%h cnt=%0d/%0d ffv=%b%b busy=%b%b, want all 0",
                     vec1, vec2, cnt1, cnt2, ffv1, ffv2, busy1, busy2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        n_vec++;
        if ({busy1, busy2, done1, done2, vec1, vec2} !== '0) begin
            n_bad++;
            $display("FAIL midreset_noresume: busy=%b%b done=%b%b vec=%h/%h, want idle at 0",
                     busy1, busy2, done1, done2, vec1, vec2);
        end
        mask1 = '0;
        mask2 = '0;
        run_sweep(-1, l1, l2, b1, b2);
        n_vec++;
        if (l2 !== 32 || b2 !== 32 || l1 !== 48 || !pass1 || !pass2 || vec2 !== 4'hF) begin
            n_bad++;
            $display("FAIL midreset_restart: lat=%0d/%0d busy2=%0d pass=%b%b vec2=%h, want 48/32 32 11 f",
                     l1, l2, b2, pass1, pass2, vec2);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_sweeps;
        test_abort;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
